// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the dcache/icache main-memory arbiter.
// Round-robin arbitration is enabled by defining ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

   localparam int MEM_ADDR_W = 6;
   localparam int MEM_DATA_W = 32;

   typedef logic req_id_t;
   localparam req_id_t REQ_D = 1'b0;
   localparam req_id_t REQ_I = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GRANT_D = 3'd1,
      ST_GRANT_I = 3'd2,
      ST_DONE_D  = 3'd3,
      ST_DONE_I  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational two-way requester picker for mem_arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin; otherwise dcache has fixed priority.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic    i_req_d,
   input  logic    i_req_i,
   input  req_id_t i_last_served,
   output logic    o_grant_valid,
   output req_id_t o_grant
);

   assign o_grant_valid = i_req_d | i_req_i;

`ifdef ARB_ROUND_ROBIN_EN
   // On contention the requester not served most recently wins.
   always_comb begin
      o_grant = REQ_D;
      if (i_req_d && i_req_i)
         o_grant = (i_last_served == REQ_D) ? REQ_I : REQ_D;
      else if (i_req_i)
         o_grant = REQ_I;
   end
`else
   logic w_unused_last;
   assign w_unused_last = i_last_served;

   always_comb begin
      o_grant = REQ_D;
      if (!i_req_d && i_req_i)
         o_grant = REQ_I;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block memory port between dcache and icache, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed dcache priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [DATA_W-1:0] d_writedata,
   output logic [DATA_W-1:0] d_readdata,
   output logic              d_busywait,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [DATA_W-1:0] i_readdata,
   output logic              i_busywait,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic              mem_busywait
);

   arb_state_t        r_state, w_state_next;
   logic              r_started, w_started_next;
   req_id_t           r_last, w_last_next;
   logic              r_mem_read, w_mem_read_next;
   logic              r_mem_write, w_mem_write_next;
   logic [ADDR_W-1:0] r_mem_address, w_mem_address_next;
   logic [DATA_W-1:0] r_mem_writedata, w_mem_writedata_next;
   logic [DATA_W-1:0] r_d_readdata, w_d_readdata_next;
   logic [DATA_W-1:0] r_i_readdata, w_i_readdata_next;

   logic    w_req_d;
   logic    w_grant_valid;
   req_id_t w_grant;

   assign w_req_d = d_read | d_write;

   arb_pick u_pick (
      .i_req_d       (w_req_d),
      .i_req_i       (i_read),
      .i_last_served (r_last),
      .o_grant_valid (w_grant_valid),
      .o_grant       (w_grant)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_started       <= 1'b0;
         r_last          <= REQ_I;
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_mem_address   <= '0;
         r_mem_writedata <= '0;
         r_d_readdata    <= '0;
         r_i_readdata    <= '0;
      end else begin
         r_state         <= w_state_next;
         r_started       <= w_started_next;
         r_last          <= w_last_next;
         r_mem_read      <= w_mem_read_next;
         r_mem_write     <= w_mem_write_next;
         r_mem_address   <= w_mem_address_next;
         r_mem_writedata <= w_mem_writedata_next;
         r_d_readdata    <= w_d_readdata_next;
         r_i_readdata    <= w_i_readdata_next;
      end
   end

   always_comb begin
      w_state_next         = r_state;
      w_started_next       = r_started;
      w_last_next          = r_last;
      w_mem_read_next      = r_mem_read;
      w_mem_write_next     = r_mem_write;
      w_mem_address_next   = r_mem_address;
      w_mem_writedata_next = r_mem_writedata;
      w_d_readdata_next    = r_d_readdata;
      w_i_readdata_next    = r_i_readdata;

      case (r_state)
         ST_IDLE: begin
            if (w_grant_valid) begin
               w_started_next = 1'b0;
               if (w_grant == REQ_D) begin
                  // A write-back takes precedence over a simultaneous read.
                  w_state_next         = ST_GRANT_D;
                  w_mem_write_next     = d_write;
                  w_mem_read_next      = d_read & ~d_write;
                  w_mem_address_next   = d_address;
                  w_mem_writedata_next = d_writedata;
               end else begin
                  w_state_next         = ST_GRANT_I;
                  w_mem_write_next     = 1'b0;
                  w_mem_read_next      = 1'b1;
                  w_mem_address_next   = i_address;
                  w_mem_writedata_next = '0;
               end
            end
         end
         ST_GRANT_D, ST_GRANT_I: begin
            // Completion only counts once memory has actually signalled busy.
            if (!r_started) begin
               if (mem_busywait)
                  w_started_next = 1'b1;
            end else if (!mem_busywait) begin
               w_started_next   = 1'b0;
               w_mem_read_next  = 1'b0;
               w_mem_write_next = 1'b0;
               if (r_state == ST_GRANT_D) begin
                  if (r_mem_read)
                     w_d_readdata_next = mem_readdata;
                  w_last_next  = REQ_D;
                  w_state_next = ST_DONE_D;
               end else begin
                  if (r_mem_read)
                     w_i_readdata_next = mem_readdata;
                  w_last_next  = REQ_I;
                  w_state_next = ST_DONE_I;
               end
            end
         end
         ST_DONE_D, ST_DONE_I: w_state_next = ST_IDLE;
         default:              w_state_next = ST_IDLE;
      endcase
   end

   assign d_busywait    = w_req_d && (r_state != ST_DONE_D);
   assign i_busywait    = i_read && (r_state != ST_DONE_I);
   assign d_readdata    = r_d_readdata;
   assign i_readdata    = r_i_readdata;
   assign mem_read      = r_mem_read;
   assign mem_write     = r_mem_write;
   assign mem_address   = r_mem_address;
   assign mem_writedata = r_mem_writedata;

endmodule
